// File: rtl/forward_hazard_unit_pkg.sv
// Shared constants and types for the operand-forwarding / load-use hazard unit.
package fwd_pkg;

  // Operand source selects presented on fwd_sel (11 is never produced).
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Stall sequencer states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } fsm_state_e;

  // Index of the hardwired-zero register when ZERO_REG is enabled.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding/hazard unit. The pipeline drives the
// master side; the unit sits on the slave side.
interface forward_hazard_unit_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16
);

  logic [NSRC*REG_AW-1:0] id_src_addr;
  logic [NSRC-1:0]        id_src_used;
  logic [NSRC*REG_AW-1:0] ex_src_addr;
  logic [NSRC*DATA_W-1:0] ex_src_data;
  logic [REG_AW-1:0]      ex_dst_addr;
  logic                   ex_wr_en;
  logic                   ex_is_load;
  logic [REG_AW-1:0]      mem_dst_addr;
  logic                   mem_wr_en;
  logic [DATA_W-1:0]      mem_alu_result;
  logic [REG_AW-1:0]      wb_dst_addr;
  logic                   wb_wr_en;
  logic [DATA_W-1:0]      wb_result;
  logic                   flush;
  logic [NSRC*DATA_W-1:0] ex_op_out;
  logic [NSRC*2-1:0]      fwd_sel;
  logic                   stall;
  logic                   bubble;
  logic [CNT_W-1:0]       stall_cycles;

  modport master (
    output id_src_addr, id_src_used, ex_src_addr, ex_src_data,
    output ex_dst_addr, ex_wr_en, ex_is_load,
    output mem_dst_addr, mem_wr_en, mem_alu_result,
    output wb_dst_addr, wb_wr_en, wb_result, flush,
    input  ex_op_out, fwd_sel, stall, bubble, stall_cycles
  );

  modport slave (
    input  id_src_addr, id_src_used, ex_src_addr, ex_src_data,
    input  ex_dst_addr, ex_wr_en, ex_is_load,
    input  mem_dst_addr, mem_wr_en, mem_alu_result,
    input  wb_dst_addr, wb_wr_en, wb_result, flush,
    output ex_op_out, fwd_sel, stall, bubble, stall_cycles
  );

endinterface

// File: rtl/forward_hazard_unit_operand_mux.sv
// Compare-and-select for one ALU source operand: picks the regfile value held
// in ID/EX, the EX/MEM ALU result, or the MEM/WB write-back value.
module fwd_operand_mux
  import fwd_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  input  logic [REG_AW-1:0] mem_dst_addr,
  input  logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [REG_AW-1:0] wb_dst_addr,
  input  logic              wb_wr_en,
  input  logic [DATA_W-1:0] wb_result,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] op_out
);

  logic src_live;

  // Youngest producer wins: EX/MEM before MEM/WB; r0 is never forwarded when hardwired.
  always_comb begin
    src_live = !((ZERO_REG != 0) && (src_addr == REG_AW'(REG_ZERO)));
    sel      = FWD_RF;
    op_out   = src_data;
    if (src_live && mem_wr_en && (mem_dst_addr == src_addr)) begin
      sel    = FWD_EXMEM;
      op_out = mem_alu_result;
    end else if (src_live && wb_wr_en && (wb_dst_addr == src_addr)) begin
      sel    = FWD_MEMWB;
      op_out = wb_result;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding for the EX stage plus load-use hazard detection with a
// counted stall/bubble sequence and a saturating stall-cycle counter.
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  forward_hazard_unit_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'(IDLE);
  localparam logic [0:0] S_STALL = 1'(STALL);
  localparam logic [2:0] LAT_M1  = 3'(LOAD_LAT - 1);

  logic [1:0]        sel_arr [NSRC];
  logic [DATA_W-1:0] op_arr  [NSRC];

  logic [0:0]       state_reg, state_next;
  logic [2:0]       rem_reg, rem_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             hazard;
  logic             stall_c;

  // One forwarding mux per source operand.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      fwd_operand_mux #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG)
      ) u_mux (
        .src_addr       (bus.ex_src_addr[gi*REG_AW +: REG_AW]),
        .src_data       (bus.ex_src_data[gi*DATA_W +: DATA_W]),
        .mem_dst_addr   (bus.mem_dst_addr),
        .mem_wr_en      (bus.mem_wr_en),
        .mem_alu_result (bus.mem_alu_result),
        .wb_dst_addr    (bus.wb_dst_addr),
        .wb_wr_en       (bus.wb_wr_en),
        .wb_result      (bus.wb_result),
        .sel            (sel_arr[gi]),
        .op_out         (op_arr[gi])
      );
    end
  endgenerate

  // Pack the per-operand selects and data onto the flat output buses.
  always_comb begin
    bus.fwd_sel   = '0;
    bus.ex_op_out = '0;
    for (int i = 0; i < NSRC; i++) begin
      bus.fwd_sel[i*2 +: 2]        = sel_arr[i];
      bus.ex_op_out[i*DATA_W +: DATA_W] = op_arr[i];
    end
  end

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    logic hit;
    logic [REG_AW-1:0] a;
    hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      a = bus.id_src_addr[i*REG_AW +: REG_AW];
      if (bus.id_src_used[i] && (a == bus.ex_dst_addr) &&
          !((ZERO_REG != 0) && (a == REG_AW'(REG_ZERO))))
        hit = 1'b1;
    end
    hazard = bus.ex_is_load && bus.ex_wr_en && hit;
  end

  // Stall sequencer: the first stall cycle is the detection cycle itself, the
  // remaining LOAD_LAT-1 cycles are counted down in STALL. Flush cancels at once.
  always_comb begin
    stall_c    = 1'b0;
    state_next = state_reg;
    rem_next   = rem_reg;
    if (bus.flush) begin
      state_next = S_IDLE;
      rem_next   = 3'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (hazard) begin
            stall_c = 1'b1;
            if (LOAD_LAT > 1) begin
              state_next = S_STALL;
              rem_next   = LAT_M1;
            end
          end
        end
        default: begin
          stall_c = 1'b1;
          if (rem_reg <= 3'd1) begin
            state_next = S_IDLE;
            rem_next   = 3'd0;
          end else begin
            rem_next = rem_reg - 3'd1;
          end
        end
      endcase
    end
    if (rst) stall_c = 1'b0;
  end

  // Sequencer state and remaining-cycle count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      rem_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else if (stall_c && (cnt_reg != {CNT_W{1'b1}}))
      cnt_reg <= cnt_reg + 1'b1;
  end

  assign bus.stall        = stall_c;
  assign bus.bubble       = stall_c;
  assign bus.stall_cycles = cnt_reg;

endmodule

// File: doc/forward_hazard_unit.md
# forward_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the 5-stage datapath. Sits between the ID/EX register and the ALU input. For each of NSRC source operands it selects regfile, EX/MEM, or MEM/WB data. It also detects load-use hazards against the instruction in ID and drives a counted stall/bubble sequence sized for single- or multi-cycle data memory. A saturating counter records stall cycles for performance monitoring.

## Interface
- DATA_W, 16, operand/result width
- REG_AW, 4, register address width
- NSRC, 2, source operands per instruction
- LOAD_LAT, 1, stall cycles per load-use hazard (1..7)
- ZERO_REG, 1, when 1 register 0 is hardwired and never forwarded nor stalled on
- CNT_W, 16, stall-counter width
- clk  in  1  clock; single clock domain, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_src_addr  in  NSRC*REG_AW  source registers of instruction in ID
- id_src_used  in  NSRC  per-operand valid for ID instruction
- ex_src_addr  in  NSRC*REG_AW  source registers held in ID/EX
- ex_src_data  in  NSRC*DATA_W  regfile values held in ID/EX
- ex_dst_addr, ex_wr_en, ex_is_load  in  REG_AW,1,1  destination info of instruction in EX
- mem_dst_addr, mem_wr_en  in  REG_AW,1  EX/MEM destination
- mem_alu_result  in  DATA_W  EX/MEM ALU result
- wb_dst_addr, wb_wr_en  in  REG_AW,1  MEM/WB destination
- wb_result  in  DATA_W  MEM/WB write-back value (DM or ALU)
- flush  in  1  branch/jump flush; cancels pending stall
- ex_op_out  out  NSRC*DATA_W  forwarded operands to ALU
- fwd_sel  out  NSRC*2  per-operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- stall  out  1  hold PC and IF/ID
- bubble  out  1  zero ID/EX control
- stall_cycles  out  CNT_W  saturating count of stalled cycles

## Operation
- Forwarding, per operand i, combinational:
  - 10 if mem_wr_en and mem_dst_addr==ex_src_addr[i] and not zero-reg.
  - Else 01 if the same test passes for WB.
  - Else 00.
  - EX/MEM has priority over MEM/WB. Code 11 is never generated.
- ex_op_out[i] follows fwd_sel[i]: ex_src_data[i], mem_alu_result, or wb_result.
- Hazard: ex_is_load & ex_wr_en & (ex_dst_addr matches any id_src_addr[i] with id_src_used[i]) & not zero-reg.
- FSM states: IDLE, STALL; 3-bit down-counter rem.
  - IDLE: on hazard & !flush, drive stall=1 and bubble=1 combinationally this cycle.
    - If LOAD_LAT>1, go to STALL with rem=LOAD_LAT-1.
    - Otherwise remain in IDLE.
  - STALL: stall=1, bubble=1, rem decrements each cycle. Go to IDLE when rem reaches 1 at the clock edge. New hazards are ignored in STALL.
  - flush in any state: stall=bubble=0 in that cycle, next state IDLE, rem=0.
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones; there is no wrap.

## Timing
- Forwarding path is purely combinational, zero latency.
- Each hazard gives exactly LOAD_LAT consecutive stall cycles, the first in the detection cycle.
- Reset values: state IDLE, rem 0, stall_cycles 0. stall and bubble are forced 0 while rst is high.
- fwd_sel and ex_op_out stay combinational during reset.
- Reset asserted mid-STALL aborts the sequence immediately. After release the FSM is in IDLE and hazard detection restarts from current inputs.
- Hazard and flush in the same cycle: flush wins and no stall is counted.
- A hazard in the cycle the FSM returns to IDLE is detected normally, giving back-to-back sequences.

## Structure
- Package fwd_pkg holds: FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01; the state enum {IDLE, STALL}; and a REG_ZERO constant.
- Sub-module fwd_operand_mux does the compare and select for one operand. It is instantiated NSRC times by a generate loop.
- Hazard compare, FSM and counter live in the top level.

## Test plan
- ex_src_addr[0]=3, mem_dst=3/wr, wb_dst=3/wr, mem=0x1111, wb=0x2222 -> fwd_sel[0]=10, ex_op_out[0]=0x1111. Drop mem_wr_en -> 01, 0x2222.
- ZERO_REG=1, all sources and destinations =0 with writes and load -> fwd_sel=00 everywhere, stall=0.
- LOAD_LAT=1, load to r5 in EX, ID uses r5 -> stall=bubble=1 for exactly 1 cycle; stall_cycles=1.
- LOAD_LAT=3, same hazard -> stall=1 for 3 cycles. Assert flush in cycle 2 -> stall=0 that cycle, stall_cycles=1, FSM back to IDLE.
- rst pulsed in the 2nd cycle of a LOAD_LAT=3 stall -> stall=0 immediately, stall_cycles=0, no residual stall after release.
- CNT_W=4, hold a hazard continuously for 20 cycles with LOAD_LAT=1 -> stall_cycles saturates at 15.
